// File: rtl/dvi_decoder_align.sv
// dvi_decoder_align: per-channel TMDS word aligner and 10b->8b decoder for the DVI receiver.
// Optional lock-loss counter (err_cnt_o) is built only when DVI_DECODER_ERRCNT_EN is defined.
module dvi_decoder_align #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic        pclk_i,
  input  logic        reset_i,
  input  logic [9:0]  din_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic [7:0]  dout_o,
  output logic        c0_o,
  output logic        c1_o,
  output logic        de_o
`ifdef DVI_DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int TMAX = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(CTRL_RUN + 1);

  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SLIP_SETTLE - 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(CTRL_RUN);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Undo the transition-minimising stage of the TMDS encoder.
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] m;
    logic [7:0] d;
    m    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = m[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    end
    return d;
  endfunction

  logic [9:0]    din_q;
  logic          tok_hit_q, tok_hit_d;
  logic [1:0]    tok_cc_q, tok_cc_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          run_ok_s;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    slip_cnt_q;
  logic          bitslip_q, locked_q;
  logic [7:0]    dout_q, dout_d;
  logic          c0_q, c0_d, c1_q, c1_d, de_q, de_d;
`ifdef DVI_DECODER_ERRCNT_EN
  logic [15:0]   err_cnt_q;
`endif

  always_comb begin
    tok_hit_d = 1'b1;
    tok_cc_d  = 2'b00;
    case (din_i)
      TOK_00:  tok_cc_d = 2'b00;
      TOK_01:  tok_cc_d = 2'b01;
      TOK_10:  tok_cc_d = 2'b10;
      TOK_11:  tok_cc_d = 2'b11;
      default: tok_hit_d = 1'b0;
    endcase
  end

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      din_q     <= 10'd0;
      tok_hit_q <= 1'b0;
      tok_cc_q  <= 2'b00;
    end else begin
      din_q     <= din_i;
      tok_hit_q <= tok_hit_d;
      tok_cc_q  <= tok_cc_d;
    end
  end

  // Token run length; run_ok fires on the cycle the run reaches (or stays at) CTRL_RUN.
  always_comb begin
    run_cnt_d = '0;
    if (state_q == ST_SETTLE) begin
      run_cnt_d = '0;
    end else if (tok_hit_q) begin
      run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + RW'(1);
    end else begin
      run_cnt_d = '0;
    end
  end

  assign run_ok_s = (run_cnt_d == RUN_MAX);

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  // Alignment FSM; bitslip and locked are registered alongside the state.
  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_SEARCH;
      timer_q    <= '0;
      slip_cnt_q <= 4'd0;
      bitslip_q  <= 1'b0;
      locked_q   <= 1'b0;
`ifdef DVI_DECODER_ERRCNT_EN
      err_cnt_q  <= 16'd0;
`endif
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (run_ok_s) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
            timer_q  <= '0;
          end else if (timer_q == SEARCH_LAST) begin
            state_q   <= ST_SLIP;
            bitslip_q <= 1'b1;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_SLIP: begin
          state_q    <= ST_SETTLE;
          bitslip_q  <= 1'b0;
          timer_q    <= '0;
          slip_cnt_q <= (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
        end
        ST_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_q <= ST_SEARCH;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_LOCKED: begin
          if (run_ok_s) begin
            timer_q <= '0;
          end else if (timer_q == LOCK_LAST) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
            timer_q  <= '0;
`ifdef DVI_DECODER_ERRCNT_EN
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
              err_cnt_q <= err_cnt_q;
            end
`endif
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q   <= ST_SEARCH;
          timer_q   <= '0;
          bitslip_q <= 1'b0;
          locked_q  <= 1'b0;
        end
      endcase
    end
  end

  // S2 output values; everything is forced to zero until alignment is declared.
  always_comb begin
    dout_d = 8'd0;
    de_d   = 1'b0;
    c0_d   = 1'b0;
    c1_d   = 1'b0;
    if (!locked_q) begin
      dout_d = 8'd0;
      de_d   = 1'b0;
    end else if (tok_hit_q) begin
      dout_d = 8'd0;
      de_d   = 1'b0;
      c0_d   = tok_cc_q[0];
      c1_d   = tok_cc_q[1];
    end else begin
      dout_d = tmds_decode(din_q);
      de_d   = 1'b1;
      c0_d   = c0_q;
      c1_d   = c1_q;
    end
  end

  always_ff @(posedge pclk_i or posedge reset_i) begin
    if (reset_i) begin
      dout_q <= 8'd0;
      de_q   <= 1'b0;
      c0_q   <= 1'b0;
      c1_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      de_q   <= de_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign dout_o    = dout_q;
  assign de_o      = de_q;
  assign c0_o      = c0_q;
  assign c1_o      = c1_q;
`ifdef DVI_DECODER_ERRCNT_EN
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dvi_decoder_align.sv
// Directed/random bench for dvi_decoder_align: TMDS encoder model plus a bit-level deserialiser model.
module tb_dvi_decoder_align;

  localparam int CTRL_RUN  = 8;
  localparam int SEARCH_TO = 64;
  localparam int SETTLE    = 4;
  localparam int LOCK_TO   = 256;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  din = 10'd0;
  logic        bitslip, locked, c0, c1, de;
  logic [7:0]  dout;
`ifdef DVI_DECODER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int disp = 0;
  logic [9:0] prev_w;
  logic [7:0] prev_b;
  logic [1:0] last_cc;

  always #5 pclk = ~pclk;

  dvi_decoder_align #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_TIMEOUT(SEARCH_TO),
    .SLIP_SETTLE(SETTLE), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .pclk_i(pclk), .reset_i(reset), .din_i(din),
    .bitslip_o(bitslip), .locked_o(locked), .dout_o(dout),
    .c0_o(c0), .c1_o(c1), .de_o(de)
`ifdef DVI_DECODER_ERRCNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [9:0] w);
    din = w;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick(10'd0);
    reset = 1'b0;
  endtask

  function automatic logic is_tok(input logic [9:0] w);
    return (w == T00) || (w == T01) || (w == T10) || (w == T11);
  endfunction

  function automatic logic [1:0] tok_cc(input logic [9:0] w);
    logic [1:0] r;
    case (w)
      T01:     r = 2'b01;
      T10:     r = 2'b10;
      T11:     r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Transmit-side TMDS encoder with running disparity.
  task automatic enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  // Locked-mode expectation: outputs now reflect the word sent one tick earlier.
  task automatic chk_out(input string tag);
    if (is_tok(prev_w)) begin
      last_cc = tok_cc(prev_w);
      chk({tag, "_de"}, 32'(de), 32'd0);
      chk({tag, "_dout"}, 32'(dout), 32'd0);
    end else begin
      chk({tag, "_de"}, 32'(de), 32'd1);
      chk({tag, "_dout"}, 32'(dout), 32'(prev_b));
    end
    chk({tag, "_cc"}, 32'({c1, c0}), 32'(last_cc));
  endtask

  task automatic send_tok(input string tag, input logic [9:0] w);
    tick(w);
    chk_out(tag);
    prev_w = w;
  endtask

  task automatic send_data(input string tag, input logic [7:0] b);
    logic [9:0] w;
    enc(b, w);
    tick(w);
    chk_out(tag);
    prev_w = w;
    prev_b = b;
  endtask

  function automatic logic [9:0] rot_word(input logic [9:0] tok, input int off);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = tok[(i + off) % 10];
    return r;
  endfunction

  initial begin
    logic [9:0] w;
    logic [7:0] b;
    int nslip, last_slip, prev_bs, off;

    // Reset state
    do_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cc", 32'({c1, c0}), 32'd0);
`ifdef DVI_DECODER_ERRCNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif

    // 16 control tokens: lock one cycle after the 8th token is in S1
    for (int i = 1; i <= 16; i++) begin
      tick(T00);
      chk("run_locked", 32'(locked), (i >= CTRL_RUN + 1) ? 32'd1 : 32'd0);
      chk("run_bitslip", 32'(bitslip), 32'd0);
      chk("run_de", 32'(de), 32'd0);
      chk("run_cc", 32'({c1, c0}), 32'd0);
    end

    // Known byte 0xA5: not visible after one tick, decoded after two
    prev_w  = T00;
    prev_b  = 8'd0;
    last_cc = 2'b00;
    send_data("a5_early", 8'hA5);
    send_data("a5_out", 8'h00);
    chk("a5_value", 32'(dout), 32'hA5);
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      send_data("rnd_data", b);
    end
    for (int i = 0; i < CTRL_RUN; i++) send_tok("refresh_tok", T00);
    chk("still_locked", 32'(locked), 32'd1);

    // Alternating 01/11 tokens while locked
    for (int i = 0; i < 12; i++) send_tok("alt_tok", (i % 2 == 0) ? T01 : T11);
    send_tok("alt_tail", T10);

    // No tokens for LOCK_TO cycles drops the lock
    for (int n = 1; n <= LOCK_TO + 2; n++) begin
      b = 8'($urandom_range(0, 255));
      if (n <= LOCK_TO + 1) begin
        send_data("lto_data", b);
      end else begin
        enc(b, w);
        tick(w);
        chk("lto_zero_de", 32'(de), 32'd0);
        chk("lto_zero_dout", 32'(dout), 32'd0);
        chk("lto_zero_cc", 32'({c1, c0}), 32'd0);
      end
      if (n >= LOCK_TO) chk("lto_locked", 32'(locked), (n <= LOCK_TO) ? 32'd1 : 32'd0);
    end
`ifdef DVI_DECODER_ERRCNT_EN
    chk("lto_errcnt", 32'(err_cnt), 32'd1);
`endif

    // A data word breaks the run; 8 fresh tokens are needed afterwards
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick((i % 2 == 0) ? T01 : T11);
      chk("brk_pre_locked", 32'(locked), 32'd0);
    end
    enc(8'h3C, w);
    tick(w);
    chk("brk_data_locked", 32'(locked), 32'd0);
    for (int i = 1; i <= CTRL_RUN + 1; i++) begin
      tick((i % 2 == 0) ? T11 : T01);
      chk("brk_fresh_locked", 32'(locked), (i == CTRL_RUN + 1) ? 32'd1 : 32'd0);
    end

    // Stream three bits off: expect exactly three slips, then lock
    do_reset();
    off = 7;
    nslip = 0;
    last_slip = -100;
    prev_bs = 0;
    for (int cyc = 0; cyc < 600 && !locked; cyc++) begin
      tick(rot_word(T00, off));
      if (bitslip) begin
        nslip++;
        chk("slip_width", 32'(prev_bs), 32'd0);
        if (nslip > 1) chk("slip_gap", 32'(cyc - last_slip >= SETTLE + 1), 32'd1);
        last_slip = cyc;
        off = (off + 1) % 10;
      end
      prev_bs = int'(bitslip);
    end
    chk("slip_lock", 32'(locked), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(rot_word(T00, off));
      if (bitslip) nslip++;
    end
    chk("slip_count", 32'(nslip), 32'd3);
    chk("slip_still_locked", 32'(locked), 32'd1);

    // First slip lands SEARCH_TO cycles after reset; reset during SLIP clears it at once
    do_reset();
    for (int n = 1; n <= SEARCH_TO; n++) begin
      b = 8'($urandom_range(0, 255));
      enc(b, w);
      tick(w);
      if (n >= SEARCH_TO - 1) chk("to_slip", 32'(bitslip), (n == SEARCH_TO) ? 32'd1 : 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("rst_slip_bitslip", 32'(bitslip), 32'd0);
    chk("rst_slip_locked", 32'(locked), 32'd0);
    tick(10'd0);
    reset = 1'b0;
    for (int n = 1; n <= SEARCH_TO; n++) begin
      b = 8'($urandom_range(0, 255));
      enc(b, w);
      tick(w);
      chk("post_rst_de", 32'(de), 32'd0);
      if (n >= SEARCH_TO - 1) chk("post_rst_slip", 32'(bitslip), (n == SEARCH_TO) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
